// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the byte-enabled RAM family.
//   RDW_OLD_DATA / RDW_NEW_DATA : read-during-write mode selectors
//   MAX_DATA_WIDTH              : widest word the byte_merge helper supports
//   byte_merge()                : lane-wise merge of an old and a new word
package ram_pkg;

  localparam int RDW_OLD_DATA   = 0;
  localparam int RDW_NEW_DATA   = 1;

  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_SEL_WIDTH  = $clog2(MAX_DATA_WIDTH);

  // Lanes whose enable bit is set take new_word, all others keep old_word.
  // Operands are zero-extended to MAX_DATA_WIDTH by the caller, so one
  // function serves every word width; byte_width is a constant at each call
  // site, so the division folds away.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_DATA_WIDTH-1:0] be,
    input int unsigned               byte_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < MAX_DATA_WIDTH; b++) begin
      if (be[MAX_SEL_WIDTH'(b / byte_width)]) begin
        merged[MAX_SEL_WIDTH'(b)] = new_word[MAX_SEL_WIDTH'(b)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// ram_rd_pipe: read-side output pipeline of READ_LATENCY register stages
// carrying {valid, err, data}.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_err    : read accepted this cycle / its address was bad
//   in_data             : word sampled from the array this cycle
//   out_valid, out_err  : last-stage valid and error (err only with valid)
//   out_data            : last-stage data, held while no read completes
module ram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [READ_LATENCY-1:0] valid_q;
  logic [READ_LATENCY-1:0] err_q;
  logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];

  // Data registers only load when a valid word arrives so the output holds
  // its last value on idle cycles; err is qualified by valid at every stage
  // so it can never be seen without valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      err_q[0]   <= in_valid & in_err;
      if (in_valid) begin
        data_q[0] <= in_data;
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        err_q[s]   <= valid_q[s-1] & err_q[s-1];
        if (valid_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  assign out_valid = valid_q[READ_LATENCY-1];
  assign out_err   = err_q[READ_LATENCY-1];
  assign out_data  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: simple dual-port synchronous RAM, byte-enabled write
// port plus independent read port with 1- or 2-cycle latency.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_data, wr_be    : write request, per-lane enables
//   wr_err                            : one-cycle pulse after a bad write address
//   rd_en, rd_addr                    : read request
//   rd_data, rd_valid, rd_err         : read result, strobe, bad-address flag
// The array itself is never reset; only the pipeline and flags are.
module dual_port_ram_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int DEPTH        = 16,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  output logic                             wr_err,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             rd_err
);

  // Parameter sanity checks, resolved at elaboration.
  if (BYTE_WIDTH < 1) begin : g_bad_byte_width
    $fatal(1, "dual_port_ram_be: BYTE_WIDTH must be at least 1");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
    $fatal(1, "dual_port_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
    $fatal(1, "dual_port_ram_be: DATA_WIDTH exceeds ram_pkg::MAX_DATA_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "dual_port_ram_be: READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 1) begin : g_bad_depth_low
    $fatal(1, "dual_port_ram_be: DEPTH must be at least 1");
  end
  if (DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth_high
    $fatal(1, "dual_port_ram_be: DEPTH exceeds the address space");
  end

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  collision;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] s1_data;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIMIT);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIMIT);

  // Array reads are guarded so an out-of-range address never indexes past
  // the array; a bad read address yields a zero word.
  assign wr_old = wr_in_range ? mem[wr_addr] : '0;
  assign rd_old = rd_in_range ? mem[rd_addr] : '0;

  assign wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(wr_old),
                                            MAX_DATA_WIDTH'(wr_data),
                                            MAX_DATA_WIDTH'(wr_be),
                                            BYTE_WIDTH));

  assign collision = wr_en && rd_en && wr_in_range && rd_in_range &&
                     (wr_addr == rd_addr);

  // Byte-merged write; wr_be == 0 rewrites the old word, a harmless no-op.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_in_range;
    end
  end

  // On a same-address collision in new-data mode the merged write word is
  // forwarded, since the array still holds the pre-write value this cycle.
  always_comb begin
    s1_data = rd_old;
    if (RDW_MODE == RDW_NEW_DATA && collision) begin
      s1_data = wr_merged;
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_en),
    .in_err   (!rd_in_range),
    .in_data  (s1_data),
    .out_valid(rd_valid),
    .out_err  (rd_err),
    .out_data (rd_data)
  );

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- Simple dual-port synchronous RAM: one write port with byte enables, one independent read port.
- Read latency is configurable (1 or 2 cycles); a valid strobe is pipelined alongside the data.
- Read-during-write behaviour is selectable; out-of-range accesses are detected and flagged.
- General-purpose storage primitive for buffers and register files; single-port usage is covered by tying the address buses together.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane.
- ADDR_WIDTH, 4, address bus width.
- DEPTH, 16, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from rd_en to rd_valid; legal values 1 or 2.
- RDW_MODE, 0, same-address read/write collision: 0 = old data, 1 = new (byte-merged) data.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- wr_be  input  DATA_WIDTH/BYTE_WIDTH  per-lane write enable; bit i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_err  output  1  registered pulse: previous-cycle write had wr_addr >= DEPTH.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data; valid when rd_valid is high.
- rd_valid  output  1  pulse, READ_LATENCY cycles after the accepted rd_en.
- rd_err  output  1  read address was out of range; aligned with rd_valid.

Behaviour:
- Reset (async assert, sync deassert expected from system):
  - rd_data, rd_valid, rd_err and wr_err go to 0 immediately.
  - All internal pipeline stages clear.
  - Memory array is not reset; contents persist across reset.
- Write path:
  - Occurs on the edge where wr_en=1 and wr_addr<DEPTH.
  - Only lanes with wr_be[i]=1 update; wr_be=0 is a legal no-op that raises no error.
  - Out-of-range write (wr_addr>=DEPTH): memory is untouched; wr_err=1 for exactly the next cycle.
- Read path, stage 1:
  - On the edge with rd_en=1, the array is sampled at rd_addr.
  - Out-of-range read: data stage is forced to 0 and err flag is set.
- Read latency:
  - READ_LATENCY=1: stage 1 drives the outputs; rd_valid is high in cycle t+1 for rd_en in cycle t.
  - READ_LATENCY=2: one extra register stage on data/valid/err; rd_valid is high in cycle t+2.
- Back-to-back reads:
  - One read accepted per cycle, no stalls; rd_valid may stay high continuously.
- Hold rule:
  - When no read completes, rd_data holds its last value and rd_valid=0.
  - rd_err is 0 whenever rd_valid=0.
- Collision (wr_en & rd_en, same in-range address, same edge):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merge; enabled lanes from wr_data, other lanes from the old word.
- Collision timing:
  - A write at the cycle after a read never affects that read, even with READ_LATENCY=2, because the array is sampled in stage 1.
- Reset mid-operation:
  - In-flight reads are discarded; no rd_valid is produced for them after reset release.
- Elaboration checks (fatal):
  - DATA_WIDTH % BYTE_WIDTH != 0.
  - READ_LATENCY not in {1,2}.
  - DEPTH > 2**ADDR_WIDTH.
  - DEPTH < 1.

Decomposition:
- Package ram_pkg holds:
  - constants RDW_OLD_DATA=0 and RDW_NEW_DATA=1;
  - a byte-merge function (old word, new word, enable vector -> merged word) shared by the write path and the RDW_MODE=1 bypass.
- Sub-module ram_rd_pipe:
  - parametrised by DATA_WIDTH and READ_LATENCY;
  - registers {valid, err, data} with async active-low reset and data hold-on-idle;
  - reused by future RAM/FIFO variants.

Test Plan:
- Full write then read, DEPTH=16, READ_LATENCY=1:
  - Stimulus: write addr k = 32'hA5A5_0000+k with wr_be=4'hF, then read addresses 0..15 back-to-back.
  - Response: rd_valid high for 16 consecutive cycles starting 1 cycle after the first rd_en; data matches in order.
- Byte enables:
  - Stimulus: write addr 3 = 32'h1122_3344 (be=F), then 32'hAABB_CCDD with be=4'b0101, then read addr 3.
  - Response: 32'h11BB_33DD.
- Collision:
  - Stimulus: addr 5 holds 32'h0000_0000; same-cycle write 32'hFFFF_FFFF with be=4'b0011 and read of addr 5.
  - RDW_MODE=0 -> 32'h0000_0000; RDW_MODE=1 -> 32'h0000_FFFF.
  - A following read of addr 5 -> 32'h0000_FFFF in both modes.
- Latency 2 and reset:
  - Stimulus: READ_LATENCY=2, read addr 2, assert rst_n=0 one cycle later.
  - Response: rd_valid never rises for that read.
  - Stimulus: after release, read addr 2.
  - Response: rd_valid exactly 2 cycles later; data equals the pre-reset contents.
- Out-of-range, DEPTH=12, ADDR_WIDTH=4:
  - Stimulus: write addr 13.
  - Response: wr_err pulses 1 cycle; no array change, with 0..11 read back unchanged.
  - Stimulus: read addr 14.
  - Response: rd_valid=1, rd_err=1, rd_data=0.
- Idle hold:
  - Stimulus: read addr 1 (32'hDEAD_BEEF), then 5 idle cycles.
  - Response: rd_data stays 32'hDEAD_BEEF, rd_valid=0, rd_err=0 throughout.
